axi_rd_arb_n: RTL

AXI_RD_ARB_N -- requirements
Module: axi_rd_arb_n

---
 rtl/axi_rd_arb_n.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi_rd_arb_n.sv
// rtl/axi_rd_arb_n.sv - N-channel read-bus arbiter (fixed / round-robin) with IDLE-GRANT-WAIT handshake
// Optional WAIT watchdog enabled by defining AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arb_n #(
  parameter int NUM_CH = 8,
  parameter int TO_W   = 16,
  localparam int IDW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] xfer_done,
  input  logic              rr_mode,
  input  logic [TO_W-1:0]   to_limit,
  output logic [NUM_CH-1:0] grant,
  output logic [NUM_CH-1:0] busy,
  output logic [IDW-1:0]    owner_id,
  output logic              owner_vld,
  output logic              to_err
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  state_t         state;
  logic [IDW-1:0] last_owner;
  logic [IDW-1:0] fix_win;
  logic [IDW-1:0] rr_win;
  logic [IDW-1:0] win;
  logic [IDW:0]   rr_idx;
  logic           rr_found;

  always_comb begin
    fix_win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (start[i]) fix_win = IDW'(i);
    end
  end

  // Search upward from last_owner+1 and wrap; IDW+1 bits hold the pre-wrap sum.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = {1'b0, last_owner} + (IDW+1)'(k);
      if (rr_idx >= (IDW+1)'(NUM_CH)) rr_idx = rr_idx - (IDW+1)'(NUM_CH);
      if (!rr_found && start[rr_idx[IDW-1:0]]) begin
        rr_win   = rr_idx[IDW-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign win = rr_mode ? rr_win : fix_win;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= '0;
      owner_id   <= '0;
      owner_vld  <= 1'b0;
      last_owner <= IDW'(NUM_CH - 1);
      to_err     <= 1'b0;
      to_cnt     <= '0;
    end else begin
      grant  <= '0;
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|start) begin
            state      <= GRANT;
            owner_id   <= win;
            last_owner <= win;
            grant      <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
            busy       <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
            owner_vld  <= 1'b1;
            to_cnt     <= '0;
          end
        end
        GRANT: begin
          state  <= WAIT;
          to_cnt <= TO_W'(1);
        end
        WAIT: begin
          // A done arriving on the limit cycle still counts as a clean finish.
          if (xfer_done[owner_id]) begin
            state     <= IDLE;
            busy      <= '0;
            owner_vld <= 1'b0;
          end else if ((to_limit != '0) && (to_cnt == to_limit)) begin
            state     <= IDLE;
            busy      <= '0;
            owner_vld <= 1'b0;
            to_err    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_to_limit;
  assign unused_to_limit = ^to_limit;
  assign to_err = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= '0;
      owner_id   <= '0;
      owner_vld  <= 1'b0;
      last_owner <= IDW'(NUM_CH - 1);
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (|start) begin
            state      <= GRANT;
            owner_id   <= win;
            last_owner <= win;
            grant      <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
            busy       <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
            owner_vld  <= 1'b1;
          end
        end
        GRANT: state <= WAIT;
        WAIT: begin
          if (xfer_done[owner_id]) begin
            state     <= IDLE;
            busy      <= '0;
            owner_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
